// File: rtl/bgpu_pkg.sv
// Shared types for the compute-unit front end: warp scheduling state and the
// decoded instruction format handed between fetch, decode and issue.
package bgpu_pkg;

  typedef enum logic [1:0] {
    WARP_FREE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_WAITING = 2'd2
  } warp_state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_BRA  = 4'd6,
    OP_EXIT = 4'd7
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] dst;
    logic [7:0] src0;
    logic [7:0] src1;
  } inst_t;

  // Control ops change the warp's PC or lifetime, so decode must report them back.
  function automatic logic is_ctrl_op(input op_e op);
    return (op == OP_BRA) || (op == OP_EXIT);
  endfunction

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin pick of one requesting warp, starting strictly after the last
// granted index; a lock pins the grant to a previously chosen index.
module warp_rr_arbiter #(
  parameter int unsigned NumReq   = 8,
  parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic                lock_i,
  input  logic [IdxWidth-1:0] lock_idx_i,
  input  logic [IdxWidth-1:0] last_idx_i,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_valid_o
);

  logic [IdxWidth-1:0] idx;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    if (lock_i) begin
      gnt_idx_o   = lock_idx_i;
      gnt_valid_o = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NumReq; i++) begin
        idx = IdxWidth'((32'(last_idx_i) + i) % NumReq);
        if (!gnt_valid_o && req_i[idx]) begin
          gnt_idx_o   = idx;
          gnt_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetcher.sv
// Warp fetch scheduler: allocates warps, issues round-robin fetch requests to
// the instruction cache and retires/re-arms warps on decoder feedback.
//   state        | meaning
//   WARP_FREE    | slot unallocated, may accept a start request
//   WARP_READY   | has a PC to fetch, eligible for selection
//   WARP_WAITING | fetch issued, waiting for decoder feedback
module fetcher
  import bgpu_pkg::*;
#(
  parameter int unsigned PcWidth   = 32,
  parameter int unsigned NumWarps  = 8,
  parameter int unsigned WarpWidth = 32,
  localparam int unsigned WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 start_ready_o,
  input  logic                 start_valid_i,
  input  logic [PcWidth-1:0]   start_pc_i,
  input  logic [WarpWidth-1:0] start_act_mask_i,
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  input  logic                 dec_decoded_i,
  input  logic                 dec_stop_warp_i,
  input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
  output logic                 idle_o
);

  warp_state_e          state_q [NumWarps];
  warp_state_e          state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];
  logic                 lock_q, lock_d;
  logic [WidWidth-1:0]  lock_wid_q, lock_wid_d;
  logic [WidWidth-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NumWarps-1:0]  ready_vec, free_vec;
  logic [WidWidth-1:0]  gnt_idx, start_wid;
  logic                 gnt_valid, fetch_fire, start_fire, dec_hit;

  always_comb begin
    ready_vec = '0;
    free_vec  = '0;
    start_wid = '0;
    for (int unsigned i = 0; i < NumWarps; i++) begin
      ready_vec[i] = (state_q[i] == WARP_READY);
      free_vec[i]  = (state_q[i] == WARP_FREE);
    end
    for (int i = int'(NumWarps) - 1; i >= 0; i--) begin
      if (free_vec[i]) start_wid = WidWidth'(i);
    end
  end

  warp_rr_arbiter #(
    .NumReq  (NumWarps),
    .IdxWidth(WidWidth)
  ) u_arb (
    .req_i      (ready_vec),
    .lock_i     (lock_q),
    .lock_idx_i (lock_wid_q),
    .last_idx_i (rr_ptr_q),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  assign start_ready_o = |free_vec;
  assign idle_o        = &free_vec;
  assign fe_valid_o    = gnt_valid;
  assign fe_warp_id_o  = gnt_idx;
  assign fe_pc_o       = pc_q[gnt_idx];
  assign fe_act_mask_o = mask_q[gnt_idx];

  assign start_fire = start_valid_i && start_ready_o;
  assign fetch_fire = gnt_valid && ic_ready_i;
  assign dec_hit    = dec_decoded_i && (32'(dec_decoded_warp_id_i) < NumWarps) &&
                      (state_q[dec_decoded_warp_id_i] == WARP_WAITING);

  // Start, fetch and decode always touch warps in different states, so their
  // updates never collide on the same slot.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mask_d     = mask_q;
    lock_d     = lock_q;
    lock_wid_d = lock_wid_q;
    rr_ptr_d   = rr_ptr_q;
    if (start_fire) begin
      state_d[start_wid] = WARP_READY;
      pc_d[start_wid]    = start_pc_i;
      mask_d[start_wid]  = start_act_mask_i;
    end
    if (fetch_fire) begin
      state_d[gnt_idx] = WARP_WAITING;
      rr_ptr_d         = gnt_idx;
      lock_d           = 1'b0;
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_wid_d = gnt_idx;
    end
    if (dec_hit) begin
      if (dec_stop_warp_i) begin
        state_d[dec_decoded_warp_id_i] = WARP_FREE;
      end else begin
        state_d[dec_decoded_warp_id_i] = WARP_READY;
        pc_d[dec_decoded_warp_id_i]    = dec_decoded_next_pc_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumWarps; i++) begin
        state_q[i] <= WARP_FREE;
        pc_q[i]    <= '0;
        mask_q[i]  <= '0;
      end
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
      rr_ptr_q   <= WidWidth'(NumWarps - 1);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mask_q     <= mask_d;
      lock_q     <= lock_d;
      lock_wid_q <= lock_wid_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  if (NumWarps < 1) begin : g_num_warps_check
    $error("fetcher needs at least one warp");
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && dec_decoded_i) begin
      assert (dec_hit)
      else $warning("decoder feedback for warp %0d ignored: warp is not waiting",
                    dec_decoded_warp_id_i);
    end
  end
`endif

endmodule

// File: tb/tb_fetcher.sv
// Directed scoreboard bench for the fetcher with four warps: stimulus queues the
// expected fetches, a monitor checks each instruction-cache handshake.
module tb_fetcher;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_ready;
  logic        start_valid = 1'b0;
  logic [31:0] start_pc = '0;
  logic [31:0] start_mask = '0;
  logic        ic_ready = 1'b0;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_mask;
  logic [1:0]  fe_wid;
  logic        dec_decoded = 1'b0;
  logic        dec_stop = 1'b0;
  logic [1:0]  dec_wid = '0;
  logic [31:0] dec_pc = '0;
  logic        idle;

  always #5 clk = ~clk;

  fetcher #(
    .PcWidth  (32),
    .NumWarps (NW),
    .WarpWidth(32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .start_ready_o        (start_ready),
    .start_valid_i        (start_valid),
    .start_pc_i           (start_pc),
    .start_act_mask_i     (start_mask),
    .ic_ready_i           (ic_ready),
    .fe_valid_o           (fe_valid),
    .fe_pc_o              (fe_pc),
    .fe_act_mask_o        (fe_mask),
    .fe_warp_id_o         (fe_wid),
    .dec_decoded_i        (dec_decoded),
    .dec_stop_warp_i      (dec_stop),
    .dec_decoded_warp_id_i(dec_wid),
    .dec_decoded_next_pc_i(dec_pc),
    .idle_o               (idle)
  );

  typedef struct {
    int          wid;
    logic [31:0] pc;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input int wid, input logic [31:0] pc, input logic [31:0] mask);
    exp_t e;
    e.wid  = wid;
    e.pc   = pc;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fe_valid"}, 64'(fe_valid), 64'd0);
    check({tag, "_fe_pc"}, 64'(fe_pc), 64'd0);
    check({tag, "_fe_mask"}, 64'(fe_mask), 64'd0);
    check({tag, "_fe_wid"}, 64'(fe_wid), 64'd0);
    check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  // Monitor: every accepted fetch must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && fe_valid && ic_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: got warp %0d pc 0x%0h, expected no fetch", fe_wid, fe_pc);
        end else begin
          e = exp_q.pop_front();
          check("fetch_wid", 64'(fe_wid), 64'(e.wid));
          check("fetch_pc", 64'(fe_pc), 64'(e.pc));
          check("fetch_mask", 64'(fe_mask), 64'(e.mask));
        end
      end
    end
  end

  initial begin
    tick(2);
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // First launch appears on the fetch port the next cycle.
    start_valid = 1'b1; start_pc = 32'h10; start_mask = 32'hFFFF_FFFF;
    tick();
    start_valid = 1'b0;
    check("launch_fe_valid", 64'(fe_valid), 64'd1);
    check("launch_fe_wid", 64'(fe_wid), 64'd0);
    check("launch_fe_pc", 64'(fe_pc), 64'h10);
    check("launch_start_ready", 64'(start_ready), 64'd1);
    check("launch_idle", 64'(idle), 64'd0);
    expect_fetch(0, 32'h10, 32'hFFFF_FFFF);
    ic_ready = 1'b1;
    tick();
    ic_ready = 1'b0;

    // Decoder re-arms warp 0 with a new PC; eligible only after the edge.
    dec_decoded = 1'b1; dec_wid = 2'd0; dec_pc = 32'h11; dec_stop = 1'b0;
    check("rearm_not_early", 64'(fe_valid), 64'd0);
    tick();
    dec_decoded = 1'b0;
    check("rearm_fe_valid", 64'(fe_valid), 64'd1);
    check("rearm_fe_pc", 64'(fe_pc), 64'h11);
    expect_fetch(0, 32'h11, 32'hFFFF_FFFF);
    ic_ready = 1'b1;
    tick();
    ic_ready = 1'b0;

    dec_decoded = 1'b1; dec_wid = 2'd0; dec_stop = 1'b1;
    tick();
    dec_decoded = 1'b0; dec_stop = 1'b0;
    check("stop_idle", 64'(idle), 64'd1);
    check("stop_start_ready", 64'(start_ready), 64'd1);
    check("stop_fe_valid", 64'(fe_valid), 64'd0);

    // Fill all four warps, then drain with ic_ready held high.
    for (int i = 0; i < NW; i++) begin
      start_valid = 1'b1;
      start_pc    = 32'h100 * (i + 1);
      start_mask  = (32'd1 << (i + 1)) - 32'd1;
      tick();
    end
    start_valid = 1'b0;
    check("full_start_ready", 64'(start_ready), 64'd0);
    for (int i = 0; i < NW; i++) expect_fetch(i, 32'h100 * (i + 1), (32'd1 << (i + 1)) - 32'd1);
    ic_ready = 1'b1;
    tick(NW);
    check("drained_fe_valid", 64'(fe_valid), 64'd0);
    check("drained_start_ready", 64'(start_ready), 64'd0);
    ic_ready = 1'b0;

    // Make warp 1 the last grant so warp 2 would win were it not for the lock.
    dec_decoded = 1'b1; dec_wid = 2'd1; dec_pc = 32'h210;
    tick();
    dec_decoded = 1'b0;
    expect_fetch(1, 32'h210, 32'h3);
    ic_ready = 1'b1;
    tick();
    ic_ready = 1'b0;
    dec_decoded = 1'b1; dec_wid = 2'd1; dec_pc = 32'h220;
    tick();
    dec_wid = 2'd2; dec_pc = 32'h310;
    check("lock_wid_0", 64'(fe_wid), 64'd1);
    check("lock_pc_0", 64'(fe_pc), 64'h220);
    tick();
    dec_decoded = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("lock_wid_%0d", k), 64'(fe_wid), 64'd1);
      check($sformatf("lock_pc_%0d", k), 64'(fe_pc), 64'h220);
      check($sformatf("lock_valid_%0d", k), 64'(fe_valid), 64'd1);
      tick();
    end
    expect_fetch(1, 32'h220, 32'h3);
    expect_fetch(2, 32'h310, 32'h7);
    ic_ready = 1'b1;
    tick(2);
    ic_ready = 1'b0;

    // Stopping warp 3 frees it only from the next cycle on.
    check("allwait_start_ready", 64'(start_ready), 64'd0);
    dec_decoded = 1'b1; dec_wid = 2'd3; dec_stop = 1'b1;
    start_valid = 1'b1; start_pc = 32'h500; start_mask = 32'hF0;
    tick();
    dec_decoded = 1'b0; dec_stop = 1'b0;
    check("freed_start_ready", 64'(start_ready), 64'd1);
    check("freed_fe_valid", 64'(fe_valid), 64'd0);
    tick();
    start_valid = 1'b0;
    check("realloc_fe_valid", 64'(fe_valid), 64'd1);
    check("realloc_fe_wid", 64'(fe_wid), 64'd3);
    check("realloc_fe_pc", 64'(fe_pc), 64'h500);
    check("realloc_fe_mask", 64'(fe_mask), 64'hF0);
    expect_fetch(3, 32'h500, 32'hF0);
    ic_ready = 1'b1;
    tick();
    ic_ready = 1'b0;

    // Reset with warps 1..3 waiting, then stale feedback for warp 1.
    dec_decoded = 1'b1; dec_wid = 2'd0; dec_stop = 1'b1;
    tick();
    dec_decoded = 1'b0; dec_stop = 1'b0;
    check("prereset_idle", 64'(idle), 64'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_outputs("midreset");
    dec_decoded = 1'b1; dec_wid = 2'd1; dec_pc = 32'h999;
    tick();
    dec_decoded = 1'b0;
    check("stale_fe_valid", 64'(fe_valid), 64'd0);
    check("stale_idle", 64'(idle), 64'd1);

    // Round-robin search restarts at warp 0 after reset.
    start_valid = 1'b1; start_pc = 32'h40; start_mask = 32'hA;
    tick();
    start_valid = 1'b0;
    check("postreset_fe_wid", 64'(fe_wid), 64'd0);
    expect_fetch(0, 32'h40, 32'hA);
    ic_ready = 1'b1;
    tick();
    ic_ready = 1'b0;
    tick(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Param PcWidth, default 32, program counter width.
REQ-002 Param NumWarps, default 8, warps per compute unit; WidWidth = NumWarps>1 ? clog2(NumWarps) : 1.
REQ-003 Param WarpWidth, default 32, threads per warp (active-mask width).
REQ-004 clk_i  in  1  sole clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_ready_o  out  1  a FREE warp exists.
REQ-007 start_valid_i  in  1  request to launch a warp.
REQ-008 start_pc_i  in  PcWidth  initial PC of launched warp.
REQ-009 start_act_mask_i  in  WarpWidth  active mask of launched warp.
REQ-010 ic_ready_i  in  1  instruction cache accepts a fetch.
REQ-011 fe_valid_o  out  1  fetch request valid.
REQ-012 fe_pc_o / fe_act_mask_o / fe_warp_id_o  out  PcWidth / WarpWidth / WidWidth  fetch payload.
REQ-013 dec_decoded_i  in  1  decoder finished one instruction.
REQ-014 dec_stop_warp_i  in  1  decoded instruction terminates the warp.
REQ-015 dec_decoded_warp_id_i  in  WidWidth  warp the feedback refers to.
REQ-016 dec_decoded_next_pc_i  in  PcWidth  next PC for that warp.
REQ-017 idle_o  out  1  all warps FREE.

Function
REQ-018 Each warp SHALL hold state FREE, READY or WAITING, plus a PC and an active mask.
REQ-019 Start handshake (start_valid_i && start_ready_o) SHALL put the lowest-index FREE warp into READY with start_pc_i and start_act_mask_i, effective next cycle.
REQ-020 fe_valid_o SHALL be 1 iff a request is locked or at least one warp is READY; payload SHALL be the selected warp's PC, mask and id.
REQ-021 Selection SHALL be round-robin: first READY warp at index strictly after the last granted warp, wrapping from NumWarps-1 to 0; after reset the search starts at warp 0.
REQ-022 While fe_valid_o && !ic_ready_i, the selected warp and payload SHALL be locked and held stable until handshake, regardless of other warps becoming READY.
REQ-023 Fetch handshake (fe_valid_o && ic_ready_i) SHALL move the selected warp READY->WAITING, update the round-robin pointer to it, and release the lock; at most one handshake per cycle.
REQ-024 dec_decoded_i for a WAITING warp SHALL: if dec_stop_warp_i, go FREE; else load PC with dec_decoded_next_pc_i and go READY; effective next cycle.
REQ-025 dec_decoded_i naming a warp not WAITING SHALL be ignored (no state change) and flagged by a simulation assertion.
REQ-026 A warp returned to READY SHALL be eligible for selection in the cycle after dec_decoded_i (one-cycle feedback latency).
REQ-027 A warp freed in cycle N SHALL not be allocatable before cycle N+1; start_ready_o SHALL be computed from registered state only.
REQ-028 Start, fetch handshake and decode feedback in the same cycle SHALL all take effect; they target different warps by construction.
REQ-029 start_valid_i with start_ready_o=0 SHALL have no effect.
REQ-030 idle_o SHALL be combinational from registered state; no output SHALL depend combinationally on ic_ready_i except via the handshake-driven state update.

Reset
REQ-031 With rst_i high at a clock edge all warps SHALL become FREE, PCs and masks 0, lock cleared, round-robin pointer at NumWarps-1.
REQ-032 After reset: fe_valid_o=0, fe_pc_o=0, fe_act_mask_o=0, fe_warp_id_o=0, start_ready_o=1, idle_o=1.
REQ-033 Reset mid-operation SHALL discard in-flight fetches; subsequent decoder feedback for pre-reset warps is ignored per REQ-025.

Structure
REQ-034 Warp state enum (FREE/READY/WAITING) SHALL live in the shared bgpu package, alongside the instruction typedefs.
REQ-035 Round-robin selection SHALL be a sub-module warp_rr_arbiter (request vector, lock, grant index, grant valid).
REQ-036 Non-synthesis assertions SHALL check NumWarps>=1 and REQ-025.

Verification (NumWarps=4)
REQ-037 Reset then start pc=0x10 mask=0xFFFFFFFF -> next cycle fe_valid_o=1, fe_warp_id_o=0, fe_pc_o=0x10; start_ready_o stays 1.
REQ-038 Warps 0..3 READY, ic_ready_i=1 constant -> grants 0,1,2,3 in consecutive cycles, then fe_valid_o=0, start_ready_o=0.
REQ-039 ic_ready_i=0 for 5 cycles while warp 2 becomes READY during lock on warp 1 -> payload stays warp 1 all 5 cycles; grant after release is warp 1 then warp 2.
REQ-040 Warp 0 WAITING, dec_decoded_i with next_pc=0x11, stop=0 -> warp 0 refetched at 0x11 no earlier than one cycle later; stop=1 instead -> warp 0 FREE, idle_o=1 if others FREE.
REQ-041 Stop for warp 3 and start_valid_i in same cycle with only warp 3 allocated-free candidate -> start not accepted that cycle; accepted next cycle into warp 3.
REQ-042 rst_i asserted with 3 warps WAITING -> all outputs per REQ-032 next cycle; late dec_decoded_i for warp 1 ignored.
